// File: rtl/frame_parser_if.sv
// ----------------------------------------------------------------------------
// frame_parser_if
// Valid/ready stream bundle used on both sides of frame_parser.
//   tdata  : stream data word, DW bits
//   tvalid : producer has a word on tdata
//   tready : consumer takes the word when tvalid && tready
//   tlast  : last word of a packet (used on the output side only)
// Modports:
//   master : drives tdata/tvalid/tlast, observes tready
//   slave  : observes tdata/tvalid, drives tready (tlast is ignored on input)
// ----------------------------------------------------------------------------
interface frame_parser_if #(
   parameter int DW = 128
) ();

   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tready;
   logic          tlast;

   modport master (
      output tdata,
      output tvalid,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      output tready
   );

endinterface

// File: rtl/frame_parser.sv
// ----------------------------------------------------------------------------
// frame_parser
// Splits a framed input stream into payload and per-frame side information.
// Each frame is DATA_BEATS payload words, META_BEATS metadata words and one
// sequence word. Payload words are forwarded through a one-entry output
// register; metadata and sequence words are consumed locally. At the end of
// each frame the first metadata word and the sequence value are published,
// and a gap in the sequence numbering is flagged and counted.
//
// Ports:
//   clk        : single clock for all logic
//   resetn     : asynchronous, active-low reset
//   axis_in    : framed input stream (slave modport; tdata/tvalid in, tready out)
//   axis_out   : payload-only output stream (master modport; tdata/tvalid/tlast
//                out, tready in)
//   frame_meta : first metadata word of the last completed frame
//   frame_seq  : sequence value (low SEQ_W bits) of the last completed frame
//   frame_done : one-cycle pulse when a frame completes
//   seq_error  : one-cycle pulse, coincident with frame_done, on a sequence gap
//   err_count  : saturating count of seq_error pulses
//   state_o    : current parse state (0 DATA, 1 META, 2 SEQ)
// ----------------------------------------------------------------------------
module frame_parser #(
   parameter int DW         = 128,
   parameter int DATA_BEATS = 129,
   parameter int META_BEATS = 2,
   parameter int SEQ_W      = 64
) (
   input  logic                 clk,
   input  logic                 resetn,
   frame_parser_if.slave        axis_in,
   frame_parser_if.master       axis_out,
   output logic [DW-1:0]        frame_meta,
   output logic [SEQ_W-1:0]     frame_seq,
   output logic                 frame_done,
   output logic                 seq_error,
   output logic [15:0]          err_count,
   output logic [1:0]           state_o
);

   // One counter serves both the payload and metadata phases.
   localparam int MAX_BEATS = (DATA_BEATS > META_BEATS) ? DATA_BEATS : META_BEATS;
   localparam int CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

   typedef enum logic [1:0] {
      S_DATA = 2'd0,
      S_META = 2'd1,
      S_SEQ  = 2'd2
   } state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   logic             in_ready;
   logic             accept;
   logic             last_data;
   logic             last_meta;
   logic             load_out;
   logic             cap_meta;
   logic             seq_acc;
   logic             drain;

   logic [DW-1:0]    out_data_p1;
   logic             out_vld_p1;
   logic             out_last_p1;

   logic [DW-1:0]    meta_shadow;
   logic             have_prev;
   logic [15:0]      err_cnt;

   logic [SEQ_W-1:0] seq_in;
   logic             seq_bad;

   assign last_data = (cnt == CNT_W'(DATA_BEATS - 1));
   assign last_meta = (cnt == CNT_W'(META_BEATS - 1));
   assign drain     = out_vld_p1 && axis_out.tready;

   // Payload may only be taken when the output register is empty or is being
   // emptied this cycle; metadata and sequence words never back-pressure.
   always_comb begin
      in_ready = 1'b0;
      if (resetn) begin
         if (state == S_DATA) begin
            in_ready = !out_vld_p1 || axis_out.tready;
         end else begin
            in_ready = 1'b1;
         end
      end
   end

   assign accept         = axis_in.tvalid && in_ready;
   assign axis_in.tready = in_ready;

   assign seq_in  = axis_in.tdata[SEQ_W-1:0];
   // All-ones followed by zero wraps naturally in SEQ_W-bit arithmetic.
   assign seq_bad = have_prev && (seq_in != frame_seq + SEQ_W'(1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= S_DATA;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      load_out  = 1'b0;
      cap_meta  = 1'b0;
      seq_acc   = 1'b0;
      case (state)
         S_DATA: begin
            if (accept) begin
               load_out = 1'b1;
               if (last_data) begin
                  state_nxt = S_META;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         S_META: begin
            if (accept) begin
               cap_meta = (cnt == '0);
               if (last_meta) begin
                  state_nxt = S_SEQ;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         S_SEQ: begin
            if (accept) begin
               seq_acc   = 1'b1;
               state_nxt = S_DATA;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = S_DATA;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign state_o = state;

   // ---- stage p1: output register (load wins over drain, so a simultaneous
   // drain and acceptance replaces the word without a bubble) ----
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_data_p1 <= '0;
         out_vld_p1  <= 1'b0;
         out_last_p1 <= 1'b0;
      end else if (load_out) begin
         out_data_p1 <= axis_in.tdata;
         out_vld_p1  <= 1'b1;
         out_last_p1 <= last_data;
      end else if (drain) begin
         out_vld_p1  <= 1'b0;
      end
   end

   assign axis_out.tdata  = out_data_p1;
   assign axis_out.tvalid = out_vld_p1;
   assign axis_out.tlast  = out_last_p1;

   // ---- stage p1: per-frame results, published on sequence acceptance ----
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         meta_shadow <= '0;
         have_prev   <= 1'b0;
         frame_meta  <= '0;
         frame_seq   <= '0;
         frame_done  <= 1'b0;
         seq_error   <= 1'b0;
         err_cnt     <= 16'd0;
      end else begin
         frame_done <= seq_acc;
         seq_error  <= seq_acc && seq_bad;
         if (cap_meta) begin
            meta_shadow <= axis_in.tdata;
         end
         if (seq_acc) begin
            frame_meta <= meta_shadow;
            frame_seq  <= seq_in;
            have_prev  <= 1'b1;
            if (seq_bad) begin
               err_cnt <= sat_inc16(err_cnt);
            end
         end
      end
   end

   assign err_count = err_cnt;

endmodule

// File: tb/tb_frame_parser.sv
`timescale 1ns/1ps
module tb_frame_parser;

   localparam int DW = 128;
   localparam int DB = 4;
   localparam int MB = 2;
   localparam int SW = 64;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   frame_parser_if #(.DW(DW)) axis_in ();
   frame_parser_if #(.DW(DW)) axis_out ();

   logic [DW-1:0] frame_meta;
   logic [SW-1:0] frame_seq;
   logic          frame_done;
   logic          seq_error;
   logic [15:0]   err_count;
   logic [1:0]    state_o;

   frame_parser #(.DW(DW), .DATA_BEATS(DB), .META_BEATS(MB), .SEQ_W(SW)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .axis_in    (axis_in),
      .axis_out   (axis_out),
      .frame_meta (frame_meta),
      .frame_seq  (frame_seq),
      .frame_done (frame_done),
      .seq_error  (seq_error),
      .err_count  (err_count),
      .state_o    (state_o)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   typedef struct {
      logic [DW-1:0] meta;
      logic [SW-1:0] seq;
      logic          err;
      logic [15:0]   cnt;
   } frm_t;

   // reference model state
   beat_t         exp_beats[$];
   frm_t          exp_frames[$];
   int            pos;
   logic          have_prev;
   logic [SW-1:0] m_last_seq;
   logic [DW-1:0] m_meta;
   logic [15:0]   m_err;

   int            checks;
   int            errors;
   int            ready_mode;
   logic          err_preset_req;
   logic [SW-1:0] tb_seq;

   function automatic logic [DW-1:0] rnd_word();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Model: classify accepted words by position in the frame, predict the
   // payload stream and per-frame results, and compare against the outputs.
   task automatic monitor();
      beat_t         b;
      frm_t          f;
      logic [SW-1:0] s;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            exp_beats.delete();
            exp_frames.delete();
            pos       = 0;
            have_prev = 1'b0;
            m_err     = 16'd0;
         end else begin
            if (err_preset_req) m_err = 16'hFFFE;
            if (axis_out.tvalid === 1'b1 && axis_out.tready === 1'b1) begin
               checks++;
               if (exp_beats.size() == 0) begin
                  errors++;
                  $display("FAIL out_beat unexpected got data=%0h last=%0b", axis_out.tdata, axis_out.tlast);
               end else begin
                  b = exp_beats.pop_front();
                  if (axis_out.tdata !== b.data || axis_out.tlast !== b.last) begin
                     errors++;
                     $display("FAIL out_beat got data=%0h last=%0b exp data=%0h last=%0b",
                              axis_out.tdata, axis_out.tlast, b.data, b.last);
                  end
               end
            end
            if (frame_done === 1'b1) begin
               checks++;
               if (exp_frames.size() == 0) begin
                  errors++;
                  $display("FAIL frame_done unexpected got seq=%0h", frame_seq);
               end else begin
                  f = exp_frames.pop_front();
                  if (frame_meta !== f.meta || frame_seq !== f.seq || seq_error !== f.err || err_count !== f.cnt) begin
                     errors++;
                     $display("FAIL frame_result got meta=%0h seq=%0h err=%0b cnt=%0h exp meta=%0h seq=%0h err=%0b cnt=%0h",
                              frame_meta, frame_seq, seq_error, err_count, f.meta, f.seq, f.err, f.cnt);
                  end
               end
            end else begin
               checks++;
               if (seq_error !== 1'b0) begin
                  errors++;
                  $display("FAIL seq_error_without_done got=%0b exp=0", seq_error);
               end
            end
            if (axis_in.tvalid === 1'b1 && axis_in.tready === 1'b1) begin
               if (pos < DB) begin
                  b.data = axis_in.tdata;
                  b.last = (pos == DB - 1);
                  exp_beats.push_back(b);
               end else if (pos == DB) begin
                  m_meta = axis_in.tdata;
               end else if (pos == DB + MB) begin
                  s      = axis_in.tdata[SW-1:0];
                  f.err  = have_prev && (s != m_last_seq + 64'd1);
                  if (f.err && m_err != 16'hFFFF) m_err = m_err + 16'd1;
                  f.meta = m_meta;
                  f.seq  = s;
                  f.cnt  = m_err;
                  exp_frames.push_back(f);
                  have_prev  = 1'b1;
                  m_last_seq = s;
               end
               pos = (pos == DB + MB) ? 0 : pos + 1;
            end
         end
      end
   endtask

   task automatic ready_driver();
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       axis_out.tready = 1'b1;
            1:       axis_out.tready = 1'b0;
            2:       axis_out.tready = ~axis_out.tready;
            default: axis_out.tready = 1'($urandom_range(0, 1));
         endcase
      end
   endtask

   // Present one word and hold it until accepted; returns 1ns after the
   // accepting edge.
   task automatic send_beat(input logic [DW-1:0] d);
      int n;
      n = 0;
      axis_in.tdata  = d;
      axis_in.tvalid = 1'b1;
      @(negedge clk);
      while (axis_in.tready !== 1'b1 && n < 500) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n >= 500) begin
         errors++;
         $display("FAIL send_timeout got tready=%0b exp=1 within 500 cycles", axis_in.tready);
      end
      @(posedge clk);
      #1;
      axis_in.tvalid = 1'b0;
   endtask

   task automatic gap(input logic en);
      if (en) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic send_frame(input logic rnd, input logic [DW-1:0] base, input logic [DW-1:0] ma,
                             input logic [DW-1:0] mb, input logic [SW-1:0] seq, input logic gaps);
      for (int i = 0; i < DB; i++) begin
         send_beat(rnd ? rnd_word() : base + DW'(i));
         gap(gaps);
      end
      send_beat(ma);
      gap(gaps);
      send_beat(mb);
      gap(gaps);
      send_beat({$urandom(), $urandom(), seq});
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      idle(2);
      checks++; if (axis_out.tvalid !== 1'b0) begin errors++; $display("FAIL reset_out_tvalid got=%0b exp=0", axis_out.tvalid); end
      checks++; if (axis_out.tdata !== '0) begin errors++; $display("FAIL reset_out_tdata got=%0h exp=0", axis_out.tdata); end
      checks++; if (axis_out.tlast !== 1'b0) begin errors++; $display("FAIL reset_out_tlast got=%0b exp=0", axis_out.tlast); end
      checks++; if (axis_in.tready !== 1'b0) begin errors++; $display("FAIL reset_in_tready got=%0b exp=0", axis_in.tready); end
      checks++; if (frame_meta !== '0 || frame_seq !== '0) begin errors++; $display("FAIL reset_frame_regs got meta=%0h seq=%0h exp 0", frame_meta, frame_seq); end
      checks++; if (frame_done !== 1'b0 || seq_error !== 1'b0) begin errors++; $display("FAIL reset_pulses got done=%0b err=%0b exp 0", frame_done, seq_error); end
      checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err_count got=%0h exp=0", err_count); end
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_o); end
      resetn = 1'b1;
      @(negedge clk);
      checks++; if (axis_in.tready !== 1'b1) begin errors++; $display("FAIL post_reset_tready got=%0b exp=1", axis_in.tready); end
      idle(1);
   endtask

   task automatic test_basic();
      logic [DW-1:0] ma;
      logic [DW-1:0] mb;
      ma = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      mb = 128'h5555_AAAA_5555_AAAA_1234_5678_9ABC_DEF0;
      ready_mode = 0;
      idle(2);
      send_beat(128'd1);
      checks++; if (axis_out.tvalid !== 1'b1 || axis_out.tdata !== 128'd1 || axis_out.tlast !== 1'b0) begin
         errors++; $display("FAIL basic_latency got vld=%0b data=%0h last=%0b exp vld=1 data=1 last=0", axis_out.tvalid, axis_out.tdata, axis_out.tlast);
      end
      send_beat(128'd2);
      send_beat(128'd3);
      send_beat(128'd4);
      checks++; if (axis_out.tdata !== 128'd4 || axis_out.tlast !== 1'b1) begin
         errors++; $display("FAIL basic_tlast got data=%0h last=%0b exp data=4 last=1", axis_out.tdata, axis_out.tlast);
      end
      checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL basic_state_meta got=%0d exp=1", state_o); end
      send_beat(ma);
      checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL basic_state_meta2 got=%0d exp=1", state_o); end
      send_beat(mb);
      checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL basic_state_seq got=%0d exp=2", state_o); end
      send_beat({64'hDEAD_BEEF_CAFE_F00D, 64'd7});
      tb_seq = 64'd7;
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL basic_state_data got=%0d exp=0", state_o); end
      checks++; if (frame_done !== 1'b1 || seq_error !== 1'b0) begin
         errors++; $display("FAIL basic_done got done=%0b err=%0b exp done=1 err=0", frame_done, seq_error);
      end
      checks++; if (frame_meta !== ma || frame_seq !== 64'd7) begin
         errors++; $display("FAIL basic_results got meta=%0h seq=%0h exp meta=%0h seq=7", frame_meta, frame_seq, ma);
      end
      idle(1);
      checks++; if (frame_done !== 1'b0 || frame_meta !== ma) begin
         errors++; $display("FAIL basic_pulse_width got done=%0b meta=%0h exp done=0 meta=%0h", frame_done, frame_meta, ma);
      end
      idle(4);
      checks++; if (exp_beats.size() != 0 || exp_frames.size() != 0) begin
         errors++; $display("FAIL basic_drain got beats=%0d frames=%0d exp 0", exp_beats.size(), exp_frames.size());
      end
   endtask

   task automatic test_seq_error();
      ready_mode = 0;
      send_frame(1'b1, '0, rnd_word(), rnd_word(), 64'd9, 1'b0);
      tb_seq = 64'd9;
      checks++; if (frame_done !== 1'b1 || seq_error !== 1'b1 || err_count !== 16'd1) begin
         errors++; $display("FAIL seq_gap got done=%0b err=%0b cnt=%0d exp done=1 err=1 cnt=1", frame_done, seq_error, err_count);
      end
      idle(2);
      send_frame(1'b1, '0, rnd_word(), rnd_word(), {SW{1'b1}}, 1'b0);
      checks++; if (seq_error !== 1'b1 || err_count !== 16'd2) begin
         errors++; $display("FAIL seq_gap2 got err=%0b cnt=%0d exp err=1 cnt=2", seq_error, err_count);
      end
      idle(2);
      send_frame(1'b1, '0, rnd_word(), rnd_word(), 64'd0, 1'b0);
      tb_seq = 64'd0;
      checks++; if (frame_done !== 1'b1 || seq_error !== 1'b0 || err_count !== 16'd2) begin
         errors++; $display("FAIL seq_wrap got done=%0b err=%0b cnt=%0d exp done=1 err=0 cnt=2", frame_done, seq_error, err_count);
      end
      idle(4);
      checks++; if (exp_beats.size() != 0 || exp_frames.size() != 0) begin
         errors++; $display("FAIL seq_drain got beats=%0d frames=%0d exp 0", exp_beats.size(), exp_frames.size());
      end
   endtask

   task automatic test_stall();
      logic [DW-1:0] p0;
      p0 = rnd_word();
      ready_mode = 1;
      idle(2);
      send_beat(p0);
      axis_in.tdata  = p0 + 128'd1;
      axis_in.tvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (axis_in.tready !== 1'b0) begin errors++; $display("FAIL stall_in_tready got=%0b exp=0", axis_in.tready); end
         checks++; if (axis_out.tvalid !== 1'b1 || axis_out.tdata !== p0) begin
            errors++; $display("FAIL stall_hold got vld=%0b data=%0h exp vld=1 data=%0h", axis_out.tvalid, axis_out.tdata, p0);
         end
      end
      ready_mode = 0;
      send_beat(p0 + 128'd1);
      send_beat(p0 + 128'd2);
      send_beat(p0 + 128'd3);
      send_beat(rnd_word());
      send_beat(rnd_word());
      tb_seq = tb_seq + 64'd1;
      send_beat({64'd0, tb_seq});
      checks++; if (seq_error !== 1'b0 || frame_done !== 1'b1) begin
         errors++; $display("FAIL stall_frame got done=%0b err=%0b exp done=1 err=0", frame_done, seq_error);
      end
      idle(4);
      checks++; if (exp_beats.size() != 0 || exp_frames.size() != 0) begin
         errors++; $display("FAIL stall_drain got beats=%0d frames=%0d exp 0", exp_beats.size(), exp_frames.size());
      end
   endtask

   task automatic test_toggle();
      ready_mode = 2;
      for (int k = 0; k < 3; k++) begin
         tb_seq = tb_seq + 64'd1;
         send_frame(1'b1, '0, rnd_word(), rnd_word(), tb_seq, 1'b0);
      end
      ready_mode = 0;
      idle(6);
      checks++; if (exp_beats.size() != 0 || exp_frames.size() != 0) begin
         errors++; $display("FAIL toggle_drain got beats=%0d frames=%0d exp 0", exp_beats.size(), exp_frames.size());
      end
   endtask

   task automatic test_random();
      ready_mode = 3;
      for (int k = 0; k < 8; k++) begin
         if ($urandom_range(0, 3) == 0) tb_seq = {$urandom(), $urandom()};
         else tb_seq = tb_seq + 64'd1;
         send_frame(1'b1, '0, rnd_word(), rnd_word(), tb_seq, 1'b1);
      end
      ready_mode = 0;
      idle(6);
      checks++; if (exp_beats.size() != 0 || exp_frames.size() != 0) begin
         errors++; $display("FAIL random_drain got beats=%0d frames=%0d exp 0", exp_beats.size(), exp_frames.size());
      end
   endtask

   task automatic test_midframe_reset();
      ready_mode = 0;
      idle(2);
      send_beat(rnd_word());
      send_beat(rnd_word());
      #2;
      resetn = 1'b0;
      #1;
      checks++; if (axis_out.tvalid !== 1'b0 || axis_out.tdata !== '0 || axis_out.tlast !== 1'b0) begin
         errors++; $display("FAIL mid_reset_out got vld=%0b data=%0h last=%0b exp 0", axis_out.tvalid, axis_out.tdata, axis_out.tlast);
      end
      checks++; if (frame_meta !== '0 || frame_seq !== '0 || err_count !== 16'd0 || state_o !== 2'd0) begin
         errors++; $display("FAIL mid_reset_regs got meta=%0h seq=%0h cnt=%0h state=%0d exp 0", frame_meta, frame_seq, err_count, state_o);
      end
      checks++; if (axis_in.tready !== 1'b0) begin errors++; $display("FAIL mid_reset_tready got=%0b exp=0", axis_in.tready); end
      @(negedge clk);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      idle(1);
      tb_seq = 64'd12345;
      send_frame(1'b0, 128'h100, rnd_word(), rnd_word(), tb_seq, 1'b0);
      checks++; if (frame_done !== 1'b1 || seq_error !== 1'b0 || err_count !== 16'd0 || frame_seq !== tb_seq) begin
         errors++; $display("FAIL mid_reset_frame got done=%0b err=%0b cnt=%0d seq=%0h exp done=1 err=0 cnt=0 seq=%0h",
                            frame_done, seq_error, err_count, frame_seq, tb_seq);
      end
      idle(4);
      checks++; if (exp_beats.size() != 0 || exp_frames.size() != 0) begin
         errors++; $display("FAIL mid_reset_drain got beats=%0d frames=%0d exp 0", exp_beats.size(), exp_frames.size());
      end
   endtask

   task automatic test_err_saturate();
      ready_mode = 0;
      force dut.err_cnt = 16'hFFFE;
      err_preset_req = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      release dut.err_cnt;
      err_preset_req = 1'b0;
      checks++; if (err_count !== 16'hFFFE) begin errors++; $display("FAIL sat_preset got=%0h exp=fffe", err_count); end
      tb_seq = tb_seq + 64'd5;
      send_frame(1'b1, '0, rnd_word(), rnd_word(), tb_seq, 1'b0);
      checks++; if (seq_error !== 1'b1 || err_count !== 16'hFFFF) begin
         errors++; $display("FAIL sat_reach got err=%0b cnt=%0h exp err=1 cnt=ffff", seq_error, err_count);
      end
      idle(2);
      tb_seq = tb_seq + 64'd5;
      send_frame(1'b1, '0, rnd_word(), rnd_word(), tb_seq, 1'b0);
      checks++; if (seq_error !== 1'b1 || err_count !== 16'hFFFF) begin
         errors++; $display("FAIL sat_hold got err=%0b cnt=%0h exp err=1 cnt=ffff", seq_error, err_count);
      end
      idle(4);
      checks++; if (exp_beats.size() != 0 || exp_frames.size() != 0) begin
         errors++; $display("FAIL sat_drain got beats=%0d frames=%0d exp 0", exp_beats.size(), exp_frames.size());
      end
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      resetn          = 1'b0;
      axis_in.tdata   = '0;
      axis_in.tvalid  = 1'b0;
      axis_in.tlast   = 1'b0;
      axis_out.tready = 1'b0;
      ready_mode      = 0;
      err_preset_req  = 1'b0;
      tb_seq          = '0;
      pos             = 0;
      have_prev       = 1'b0;
      m_last_seq      = '0;
      m_meta          = '0;
      m_err           = 16'd0;
      fork
         monitor();
         ready_driver();
      join_none
      test_reset();
      test_basic();
      test_seq_error();
      test_stall();
      test_toggle();
      test_random();
      test_midframe_reset();
      test_err_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_parser.md
FRAME_PARSER -- requirements
Module: frame_parser

Interface
REQ-001 SHALL have parameter DW, default 128, meaning stream data width in bits.
REQ-002 SHALL have parameter DATA_BEATS, default 129, meaning payload beats per frame.
REQ-003 SHALL have parameter META_BEATS, default 2, meaning metadata beats per frame, following the payload.
REQ-004 SHALL have parameter SEQ_W, default 64, meaning compared low bits of the sequence beat.
REQ-005 SHALL have port clk, input, 1, meaning the single clock for all logic.
REQ-006 SHALL have port resetn, input, 1, meaning reset; asynchronous, active-low.
REQ-007 SHALL have ports axis_in_tdata/tvalid/tready, input/input/output, DW/1/1, meaning the framed input stream.
REQ-008 SHALL have ports axis_out_tdata/tvalid/tlast, output, DW/1/1, meaning the payload-only output stream.
REQ-009 SHALL have port axis_out_tready, input, 1, meaning downstream ready.
REQ-010 SHALL have port frame_meta, output, DW, meaning the first metadata beat of the last completed frame.
REQ-011 SHALL have port frame_seq, output, SEQ_W, meaning the sequence value of the last completed frame.
REQ-012 SHALL have port frame_done, output, 1, meaning a one-cycle pulse when a frame completes.
REQ-013 SHALL have port seq_error, output, 1, meaning a one-cycle pulse on a sequence discontinuity.
REQ-014 SHALL have port err_count, output, 16, meaning a saturating count of seq_error pulses.
REQ-015 SHALL have port state_o, output, 2, meaning the current FSM state (0 DATA, 1 META, 2 SEQ).

Function
REQ-016 SHALL accept an input beat only when axis_in_tvalid && axis_in_tready; the frame is DATA_BEATS payload beats, then META_BEATS metadata beats, then 1 sequence beat.
REQ-017 SHALL implement the FSM: DATA -> META after the DATA_BEATS-th accepted beat; META -> SEQ after the META_BEATS-th; SEQ -> DATA after 1 accepted beat. No other transitions except reset.
REQ-018 SHALL use a beat counter sized for max(DATA_BEATS, META_BEATS), cleared on every state transition.
REQ-019 SHALL drive the output through a one-entry output register; in DATA, axis_in_tready = !axis_out_tvalid || axis_out_tready.
REQ-020 SHALL load an accepted payload beat into the output register the cycle after acceptance (latency 1), with axis_out_tlast = 1 only on the DATA_BEATS-th beat.
REQ-021 SHALL, when out-register drain (tvalid && tready) and a new payload acceptance occur in the same cycle, replace the contents with no bubble and no loss.
REQ-022 SHALL clear axis_out_tvalid after a drain when no new beat is loaded.
REQ-023 SHALL hold axis_in_tready = 1 in META and SEQ, and never forward metadata or sequence beats to axis_out.
REQ-024 SHALL capture the first metadata beat into a shadow register, and copy it to frame_meta on sequence-beat acceptance.
REQ-025 SHALL, on sequence-beat acceptance, load frame_seq = tdata[SEQ_W-1:0] and pulse frame_done the next cycle.
REQ-026 SHALL pulse seq_error, simultaneously with frame_done, when a previous frame exists and the new sequence != frame_seq+1 (mod 2^SEQ_W). An all-ones value followed by 0 is not an error.
REQ-027 SHALL not check the first frame after reset.
REQ-028 SHALL increment err_count on each seq_error and hold it at 16'hFFFF.
REQ-029 SHALL not stall META/SEQ on axis_out_tready; a pending payload beat stays valid until drained.

Reset
REQ-030 SHALL, on resetn low, asynchronously clear state to DATA, zero the counters, and clear the first-frame flag and shadow register.
REQ-031 SHALL, on resetn low, clear axis_out_tdata/tvalid/tlast, frame_meta, frame_seq, frame_done, seq_error and err_count to 0.
REQ-032 SHALL drive axis_in_tready = 0 while resetn is low.
REQ-033 SHALL, on reset mid-frame, discard the partial frame and treat the next accepted beat as payload beat 1.

Verification (DATA_BEATS=4, META_BEATS=2, SEQ_W=64)
REQ-034 SHALL cover: payload 1..4, meta A,B, seq 7, out_tready=1 -> axis_out 1,2,3,4 with tlast on 4; frame_done pulse; frame_meta=A; frame_seq=7; seq_error=0.
REQ-035 SHALL cover: frames seq 7 then 9 -> second frame_done with seq_error=1 and err_count=1; seq 2^64-1 then 0 -> no error.
REQ-036 SHALL cover: out_tready=0 during payload -> axis_in_tready drops after 1 beat; beat 1 held stable; then 1,2,3,4 delivered in order, none lost or duplicated.
REQ-037 SHALL cover: out_tready toggling every cycle with continuous tvalid -> exactly 4 payload beats per frame, in order, tlast only on the 4th.
REQ-038 SHALL cover: resetn pulsed low after payload beat 2 -> all outputs 0 asynchronously; the next full frame parses correctly and its seq is not checked.
REQ-039 SHALL cover: err_count preset to 16'hFFFF via 65535 bad frames (or force) -> a further error leaves 16'hFFFF.
